// File: rtl/reset_sequencer.sv
// Staged reset release gated on synchronised clock-generator locks, with per-stage
// fixed gaps or ack handshakes, ack timeout and lock-loss restart.
//
// state     | meaning
// WAIT_LOCK | all stage resets held, waiting for every lock flag
// HOLD      | locks present, counting HOLD_CYCLES before releasing stage 0
// RELEASE   | stage idx released, waiting on its gap count or ack
// RUN       | every stage released, o_all_ready high
// FAULT     | ack timed out, resets held for HOLD_CYCLES before retrying
module reset_sequencer #(
   parameter int NUM_LOCKS      = 3,
   parameter int NUM_STAGES     = 3,
   parameter int SYNC_STAGES    = 2,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGE_GAP      = 8,
   parameter logic [NUM_STAGES-1:0] ACK_MASK = 3'b001,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_LOCKS-1:0]  i_locked,
   input  logic [NUM_STAGES-1:0] i_stage_ack,
   output logic [NUM_STAGES-1:0] o_stage_reset,
   output logic                  o_all_ready,
   output logic                  o_timeout,
   output logic [7:0]            o_lock_loss_count,
   output logic [2:0]            o_state
);

   localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam int TMO_W   = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(STAGE_GAP - 1);
   localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      HOLD      = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;

   state_t                                 state;
   logic [SYNC_STAGES-1:0][NUM_LOCKS-1:0]  lock_sync;
   logic [SYNC_STAGES-1:0][NUM_STAGES-1:0] ack_sync;
   logic [CNT_W-1:0]                       cnt;
   logic [TMO_W-1:0]                       tmo_cnt;
   logic [IDX_W-1:0]                       idx;

   logic                  locks_ok;
   logic [NUM_STAGES-1:0] ack_s;
   logic                  ack_mode;
   logic                  stage_met;
   logic                  tmo_hit;

   assign locks_ok = &lock_sync[SYNC_STAGES-1];
   assign ack_s    = ack_sync[SYNC_STAGES-1];
   assign o_state  = state;

   always_comb begin
      ack_mode  = ACK_MASK[idx];
      stage_met = 1'b0;
      tmo_hit   = 1'b0;
      if (ack_mode) begin
         stage_met = ack_s[idx];
         tmo_hit   = !ack_s[idx] && (tmo_cnt == '0);
      end else begin
         stage_met = (cnt == '0);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= WAIT_LOCK;
         lock_sync         <= '0;
         ack_sync          <= '0;
         cnt               <= '0;
         tmo_cnt           <= '0;
         idx               <= '0;
         o_stage_reset     <= '1;
         o_all_ready       <= 1'b0;
         o_timeout         <= 1'b0;
         o_lock_loss_count <= '0;
      end else begin
         lock_sync <= {lock_sync[SYNC_STAGES-2:0], i_locked};
         ack_sync  <= {ack_sync[SYNC_STAGES-2:0], i_stage_ack};

         case (state)
            WAIT_LOCK: begin
               o_stage_reset <= '1;
               o_all_ready   <= 1'b0;
               if (locks_ok) begin
                  state <= HOLD;
                  cnt   <= HOLD_LOAD;
               end
            end

            HOLD: begin
               if (!locks_ok) begin
                  state         <= WAIT_LOCK;
                  o_stage_reset <= '1;
                  o_all_ready   <= 1'b0;
                  if (o_lock_loss_count != 8'hFF)
                     o_lock_loss_count <= o_lock_loss_count + 8'd1;
               end else if (cnt == '0) begin
                  state            <= RELEASE;
                  o_stage_reset[0] <= 1'b0;
                  idx              <= '0;
                  cnt              <= GAP_LOAD;
                  tmo_cnt          <= TMO_LOAD;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            RELEASE: begin
               if (!locks_ok) begin
                  state         <= WAIT_LOCK;
                  o_stage_reset <= '1;
                  o_all_ready   <= 1'b0;
                  if (o_lock_loss_count != 8'hFF)
                     o_lock_loss_count <= o_lock_loss_count + 8'd1;
               end else if (tmo_hit) begin
                  state         <= FAULT;
                  o_stage_reset <= '1;
                  o_all_ready   <= 1'b0;
                  o_timeout     <= 1'b1;
                  cnt           <= HOLD_LOAD;
               end else if (stage_met) begin
                  if (idx == LAST_IDX) begin
                     state       <= RUN;
                     o_all_ready <= 1'b1;
                  end else begin
                     // Lower bits are already clear, so clearing idx+1 keeps the thermometer.
                     o_stage_reset[idx + IDX_W'(1)] <= 1'b0;
                     idx     <= idx + IDX_W'(1);
                     cnt     <= GAP_LOAD;
                     tmo_cnt <= TMO_LOAD;
                  end
               end else begin
                  if (cnt != '0)
                     cnt <= cnt - CNT_W'(1);
                  if (tmo_cnt != '0)
                     tmo_cnt <= tmo_cnt - TMO_W'(1);
               end
            end

            RUN: begin
               if (!locks_ok) begin
                  state         <= WAIT_LOCK;
                  o_stage_reset <= '1;
                  o_all_ready   <= 1'b0;
                  if (o_lock_loss_count != 8'hFF)
                     o_lock_loss_count <= o_lock_loss_count + 8'd1;
               end
            end

            FAULT: begin
               o_stage_reset <= '1;
               o_all_ready   <= 1'b0;
               if (cnt == '0)
                  state <= WAIT_LOCK;
               else
                  cnt <= cnt - CNT_W'(1);
            end

            default: begin
               state         <= WAIT_LOCK;
               o_stage_reset <= '1;
               o_all_ready   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a short-timeout instance.
module tb_reset_sequencer;

   logic       clock;
   logic       reset;
   logic [2:0] locked;
   logic [2:0] ack;
   logic [2:0] stage_reset;
   logic       all_ready;
   logic       timeout;
   logic [7:0] loss_count;
   logic [2:0] state;

   logic       t_reset;
   logic [2:0] t_locked;
   logic [2:0] t_ack;
   logic [2:0] t_stage_reset;
   logic       t_all_ready;
   logic       t_timeout;
   logic [7:0] t_loss_count;
   logic [2:0] t_state;

   int vectors = 0;
   int miscompares = 0;

   reset_sequencer dut (
      .clock             (clock),
      .reset             (reset),
      .i_locked          (locked),
      .i_stage_ack       (ack),
      .o_stage_reset     (stage_reset),
      .o_all_ready       (all_ready),
      .o_timeout         (timeout),
      .o_lock_loss_count (loss_count),
      .o_state           (state)
   );

   reset_sequencer #(.TIMEOUT_CYCLES(50)) dut_t (
      .clock             (clock),
      .reset             (t_reset),
      .i_locked          (t_locked),
      .i_stage_ack       (t_ack),
      .o_stage_reset     (t_stage_reset),
      .o_all_ready       (t_all_ready),
      .o_timeout         (t_timeout),
      .o_lock_loss_count (t_loss_count),
      .o_state           (t_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input int observed, input int expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Released bits must always be a contiguous run starting at bit 0.
   always @(negedge clock) begin
      logic [2:0] rel;
      logic [2:0] t_rel;
      rel   = ~stage_reset;
      t_rel = ~t_stage_reset;
      vectors++;
      assert (((rel & (rel + 3'd1)) == 3'd0) && ((t_rel & (t_rel + 3'd1)) == 3'd0))
      else begin
         miscompares++;
         $error("FAIL thermometer: observed %b/%b expected thermometer", stage_reset, t_stage_reset);
      end
   end

   initial begin
      bit got_ready;
      reset    = 1'b1;
      locked   = 3'b000;
      ack      = 3'b000;
      t_reset  = 1'b1;
      t_locked = 3'b000;
      t_ack    = 3'b000;

      // reset values
      step(3);
      check("rst_stage_reset", int'(stage_reset), 7);
      check("rst_all_ready", int'(all_ready), 0);
      check("rst_timeout", int'(timeout), 0);
      check("rst_count", int'(loss_count), 0);
      check("rst_state", int'(state), 0);
      reset = 1'b0;
      step(2);
      check("wait_state", int'(state), 0);

      // test 1: normal sequence; next edge is edge 1
      locked = 3'b111;
      step(18);
      check("t1_e18_reset", int'(stage_reset), 7);
      check("t1_e18_state", int'(state), 1);
      step(1);
      check("t1_e19_reset", int'(stage_reset), 6);
      check("t1_e19_state", int'(state), 2);
      step(100);
      check("t1_noack_reset", int'(stage_reset), 6);
      ack = 3'b001;
      step(2);
      check("t1_ack_e2_reset", int'(stage_reset), 6);
      step(1);
      check("t1_stage1", int'(stage_reset), 4);
      step(7);
      check("t1_gap_e7", int'(stage_reset), 4);
      step(1);
      check("t1_stage2", int'(stage_reset), 0);
      step(7);
      check("t1_ready_e7", int'(all_ready), 0);
      step(1);
      check("t1_ready", int'(all_ready), 1);
      check("t1_run_state", int'(state), 3);

      // test 2: one-cycle glitch on lock 1 in RUN
      locked = 3'b101;
      step(1);
      locked = 3'b111;
      step(1);
      check("t2_e2_reset", int'(stage_reset), 0);
      check("t2_e2_ready", int'(all_ready), 1);
      step(1);
      check("t2_e3_reset", int'(stage_reset), 7);
      check("t2_e3_ready", int'(all_ready), 0);
      check("t2_e3_state", int'(state), 0);
      check("t2_count", int'(loss_count), 1);
      step(17);
      check("t2_restart_stage0", int'(stage_reset), 6);
      step(1);
      check("t2_restart_stage1", int'(stage_reset), 4);
      step(16);
      check("t2_restart_ready", int'(all_ready), 1);
      check("t2_restart_state", int'(state), 3);

      // test 4: lock 2 glitch during HOLD at cnt=5
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(13);
      check("t4_hold_state", int'(state), 1);
      locked = 3'b011;
      step(1);
      locked = 3'b111;
      step(2);
      check("t4_state", int'(state), 0);
      check("t4_count", int'(loss_count), 1);
      check("t4_reset", int'(stage_reset), 7);
      step(16);
      check("t4_e18_reset", int'(stage_reset), 7);
      step(1);
      check("t4_e19_reset", int'(stage_reset), 6);

      // test 5: build count to 7 via HOLD losses, then reset at idx=1
      for (int i = 0; i < 6; i++) begin
         locked = 3'b000;
         step(3);
         locked = 3'b111;
         step(3);
      end
      check("t5_count", int'(loss_count), 7);
      check("t5_hold", int'(state), 1);
      step(16);
      check("t5_stage0", int'(stage_reset), 6);
      step(1);
      check("t5_stage1", int'(stage_reset), 4);
      reset = 1'b1;
      step(1);
      check("t5_reset", int'(stage_reset), 7);
      check("t5_count_clr", int'(loss_count), 0);
      check("t5_timeout_clr", int'(timeout), 0);
      check("t5_state", int'(state), 0);
      check("t5_ready", int'(all_ready), 0);
      reset = 1'b0;

      // test 6: 300 lock losses from RUN, counter saturates
      for (int i = 0; i < 300; i++) begin
         got_ready = 1'b0;
         for (int c = 0; c < 200 && !got_ready; c++) begin
            step(1);
            if (all_ready) got_ready = 1'b1;
         end
         if (!got_ready) begin
            check("t6_ready_wait", 0, 1);
            break;
         end
         locked = 3'b110;
         step(1);
         locked = 3'b111;
         step(2);
         if (i == 253) check("t6_count_254", int'(loss_count), 254);
      end
      check("t6_count_sat", int'(loss_count), 255);
      check("t6_state", int'(state), 0);

      // test 3: short-timeout instance, ack never raised
      t_locked = 3'b111;
      t_reset  = 1'b0;
      step(19);
      check("t3_stage0", int'(t_stage_reset), 6);
      step(49);
      check("t3_pre_tmo_reset", int'(t_stage_reset), 6);
      check("t3_pre_tmo_flag", int'(t_timeout), 0);
      step(1);
      check("t3_tmo_reset", int'(t_stage_reset), 7);
      check("t3_tmo_flag", int'(t_timeout), 1);
      check("t3_fault_state", int'(t_state), 4);
      step(15);
      check("t3_fault_end", int'(t_state), 4);
      step(1);
      check("t3_wait_state", int'(t_state), 0);
      step(17);
      check("t3_retry_stage0", int'(t_stage_reset), 6);
      check("t3_retry_flag", int'(t_timeout), 1);
      check("t3_retry_count", int'(t_loss_count), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
